// File: rtl/video_tmds_encode.sv
// DVI 1.0 TMDS encoder for a 12-bit RGB stream: nibble expansion, a two-stage
// pipeline with per-channel running disparity, and control tokens while blanked.
module video_tmds_encode #(
  parameter bit INVERT_SYNC = 1'b0
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        vsync_i,
  input  logic        hsync_i,
  input  logic        dv_de_i,
  input  logic [11:0] rgb_i,
  output logic [9:0]  tmds_ch0_o,
  output logic [9:0]  tmds_ch1_o,
  output logic [9:0]  tmds_ch2_o
);

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_11 = 10'b1010101011;

  function automatic logic [3:0] popCount(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Transition-minimising stage; q_m[8] = 1 marks XOR mode, 0 marks XNOR mode.
  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] n1;
    logic       useXnor;
    logic [8:0] q;
    n1      = popCount(d);
    useXnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
    q       = '0;
    q[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = useXnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~useXnor;
    return q;
  endfunction

  function automatic logic signed [4:0] onesMinusZeros(input logic [7:0] q);
    logic [3:0] n1;
    logic [3:0] n0;
    n1 = popCount(q);
    n0 = 4'd8 - n1;
    return $signed({1'b0, n1}) - $signed({1'b0, n0});
  endfunction

  logic [2:0][7:0]   w_d;
  logic [2:0][8:0]   r_qm;
  logic              r_de;
  logic [1:0]        r_sync;
  logic [2:0][9:0]   r_sym;
  logic [2:0][9:0]   w_symNext;
  logic signed [4:0] r_cnt     [3];
  logic signed [4:0] w_cntNext [3];
  logic signed [4:0] w_diff    [3];
  logic [1:0]        w_ctl     [3];

  assign w_d[0] = {rgb_i[3:0],  rgb_i[3:0]};
  assign w_d[1] = {rgb_i[7:4],  rgb_i[7:4]};
  assign w_d[2] = {rgb_i[11:8], rgb_i[11:8]};

  // Only the blue channel carries sync; green and red always send control 00.
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_de   <= 1'b0;
      r_sync <= 2'b00;
      r_qm   <= '0;
    end else begin
      r_de   <= dv_de_i;
      r_sync <= {vsync_i ^ INVERT_SYNC, hsync_i ^ INVERT_SYNC};
      for (int ch = 0; ch < 3; ch++) begin
        r_qm[ch] <= minimise(w_d[ch]);
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < 3; ch++) begin
      w_ctl[ch]     = (ch == 0) ? r_sync : 2'b00;
      w_diff[ch]    = onesMinusZeros(r_qm[ch][7:0]);
      w_symNext[ch] = TOKEN_00;
      w_cntNext[ch] = 5'sd0;
      if (!r_de) begin
        case (w_ctl[ch])
          2'b01:   w_symNext[ch] = TOKEN_01;
          2'b10:   w_symNext[ch] = TOKEN_10;
          2'b11:   w_symNext[ch] = TOKEN_11;
          default: w_symNext[ch] = TOKEN_00;
        endcase
      end else if ((r_cnt[ch] == 5'sd0) || (w_diff[ch] == 5'sd0)) begin
        w_symNext[ch] = {~r_qm[ch][8], r_qm[ch][8],
                         r_qm[ch][8] ? r_qm[ch][7:0] : ~r_qm[ch][7:0]};
        w_cntNext[ch] = r_qm[ch][8] ? (r_cnt[ch] + w_diff[ch]) : (r_cnt[ch] - w_diff[ch]);
      end else if (((r_cnt[ch] > 5'sd0) && (w_diff[ch] > 5'sd0)) ||
                   ((r_cnt[ch] < 5'sd0) && (w_diff[ch] < 5'sd0))) begin
        // Inverting the data pulls the running disparity back toward zero.
        w_symNext[ch] = {1'b1, r_qm[ch][8], ~r_qm[ch][7:0]};
        w_cntNext[ch] = r_cnt[ch] + (r_qm[ch][8] ? 5'sd2 : 5'sd0) - w_diff[ch];
      end else begin
        w_symNext[ch] = {1'b0, r_qm[ch][8], r_qm[ch][7:0]};
        w_cntNext[ch] = r_cnt[ch] - (r_qm[ch][8] ? 5'sd0 : 5'sd2) + w_diff[ch];
      end
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int ch = 0; ch < 3; ch++) begin
        r_sym[ch] <= TOKEN_00;
        r_cnt[ch] <= 5'sd0;
      end
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        r_sym[ch] <= w_symNext[ch];
        r_cnt[ch] <= w_cntNext[ch];
      end
    end
  end

  assign tmds_ch0_o = r_sym[0];
  assign tmds_ch1_o = r_sym[1];
  assign tmds_ch2_o = r_sym[2];

endmodule
